// File: rtl/present_pkg.sv
// Shared constants, FSM encoding and PRESENT S-box / bit-permutation helpers.
package present_pkg;

   localparam int BLK_W = 64;
   localparam int RC_W  = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WIND,
      ST_ROUND,
      ST_DONE
   } state_e;

   function automatic bit key_size_ok(input int ks);
      return (ks == 80) || (ks == 128);
   endfunction

   // Nibble n of each table holds S(n) / Sinv(n).
   localparam logic [63:0] SBOX_TBL  = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] ISBOX_TBL = 64'hA970_364B_D21C_8FE5;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX_TBL[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      return ISBOX_TBL[{x, 2'b00} +: 4];
   endfunction

   // Bit i moves to 16*i mod 63; bit 63 stays put.
   function automatic logic [BLK_W-1:0] player(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 63; i++) y[(i * 16) % 63] = x[i];
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] inv_player(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 63; i++) y[i] = x[(i * 16) % 63];
      y[63] = x[63];
      return y;
   endfunction

endpackage

// File: rtl/present_if.sv
// Request / result handshake bundle between the host FIFOs and the engine.
interface present_if
   import present_pkg::*;
#(
   parameter int KEY_SIZE = 80
);
   logic                in_valid;
   logic                in_ready;
   logic                mode;
   logic [KEY_SIZE-1:0] key_in;
   logic [BLK_W-1:0]    data_in;
   logic                out_valid;
   logic                out_ready;
   logic [BLK_W-1:0]    data_out;
   logic                busy;

   modport master (
      output in_valid, mode, key_in, data_in, out_ready,
      input  in_ready, out_valid, data_out, busy
   );

   modport slave (
      input  in_valid, mode, key_in, data_in, out_ready,
      output in_ready, out_valid, data_out, busy
   );
endinterface

// File: rtl/present_key_step.sv
// One PRESENT key-schedule step, forward (dir=0) or its exact inverse (dir=1).
module present_key_step
   import present_pkg::*;
#(
   parameter int KEY_SIZE = 80
) (
   input  logic [KEY_SIZE-1:0] key,
   input  logic [RC_W-1:0]     rc,
   input  logic                dir,
   output logic [KEY_SIZE-1:0] key_out
);
   // The 128-bit schedule substitutes two top nibbles and injects rc higher up.
   localparam int RC_LSB   = (KEY_SIZE == 128) ? 62 : 15;
   localparam bit TWO_SBOX = (KEY_SIZE == 128);

   logic [KEY_SIZE-1:0] fwd;
   logic [KEY_SIZE-1:0] pre;
   logic [KEY_SIZE-1:0] inv;

   // Forward: rotl 61, S-box, rc xor.  Inverse: rc xor, Sinv, rotr 61.
   always_comb begin
      fwd = {key[KEY_SIZE-62:0], key[KEY_SIZE-1:KEY_SIZE-61]};
      fwd[KEY_SIZE-1 -: 4] = sbox(fwd[KEY_SIZE-1 -: 4]);
      if (TWO_SBOX) fwd[KEY_SIZE-5 -: 4] = sbox(fwd[KEY_SIZE-5 -: 4]);
      fwd[RC_LSB +: RC_W] = fwd[RC_LSB +: RC_W] ^ rc;

      pre = key;
      pre[RC_LSB +: RC_W] = pre[RC_LSB +: RC_W] ^ rc;
      pre[KEY_SIZE-1 -: 4] = inv_sbox(pre[KEY_SIZE-1 -: 4]);
      if (TWO_SBOX) pre[KEY_SIZE-5 -: 4] = inv_sbox(pre[KEY_SIZE-5 -: 4]);
      inv = {pre[60:0], pre[KEY_SIZE-1:61]};

      key_out = dir ? inv : fwd;
   end

endmodule

// File: rtl/present_core.sv
// Iterative PRESENT engine: one round per clock, encrypt/decrypt, with a
// single-entry cache of the fully wound-up key so repeated decrypts skip WIND.
module present_core
   import present_pkg::*;
#(
   parameter int KEY_SIZE   = 80,
   parameter int NUM_ROUNDS = 31
) (
   input logic       clk,
   input logic       rst_n,
   present_if.slave  bus
);

   if (!key_size_ok(KEY_SIZE)) begin : g_bad_key_size
      $error("present_core: KEY_SIZE must be 80 or 128");
   end
   if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_num_rounds
      $error("present_core: NUM_ROUNDS must be in 1..31");
   end

   localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(NUM_ROUNDS);

   state_e              state_q, state_d;
   logic [BLK_W-1:0]    blk_q, blk_d;
   logic [KEY_SIZE-1:0] key_q, key_d;
   logic [KEY_SIZE-1:0] orig_key_q, orig_key_d;
   logic [KEY_SIZE-1:0] cache_key_q, cache_key_d;
   logic [KEY_SIZE-1:0] cache_fin_q, cache_fin_d;
   logic                cache_valid_q, cache_valid_d;
   logic                mode_q, mode_d;
   logic [RC_W-1:0]     rc_q, rc_d;
   logic                out_valid_q, out_valid_d;
   logic [BLK_W-1:0]    data_out_q, data_out_d;

   logic                rdy;
   logic                accept;
   logic                hit;
   logic                last_round;
   logic                step_inv;
   logic [KEY_SIZE-1:0] key_nxt;
   logic [BLK_W-1:0]    mix, sub, unp, enc_blk, dec_blk, new_blk;

   // Ready is forced low while reset is held so nothing is accepted then.
   assign rdy        = rst_n && (state_q == ST_IDLE);
   assign accept     = bus.in_valid && rdy;
   assign hit        = cache_valid_q && (bus.key_in == cache_key_q);
   assign last_round = mode_q ? (rc_q == RC_ONE) : (rc_q == RC_LAST);
   // WIND always runs the schedule forward; decrypt rounds unwind it.
   assign step_inv   = (state_q == ST_ROUND) && mode_q;

   assign bus.in_ready  = rdy;
   assign bus.out_valid = out_valid_q;
   assign bus.data_out  = data_out_q;
   assign bus.busy      = (state_q != ST_IDLE);

   present_key_step #(.KEY_SIZE(KEY_SIZE)) u_key_step (
      .key     (key_q),
      .rc      (rc_q),
      .dir     (step_inv),
      .key_out (key_nxt)
   );

   // One cipher round in either direction on the current round key.
   always_comb begin
      mix     = blk_q ^ key_q[KEY_SIZE-1 -: BLK_W];
      sub     = '0;
      dec_blk = '0;
      for (int i = 0; i < 16; i++) sub[4*i +: 4] = sbox(mix[4*i +: 4]);
      enc_blk = player(sub);
      unp     = inv_player(mix);
      for (int i = 0; i < 16; i++) dec_blk[4*i +: 4] = inv_sbox(unp[4*i +: 4]);
      new_blk = mode_q ? dec_blk : enc_blk;
   end

   // State register and all datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         blk_q         <= '0;
         key_q         <= '0;
         orig_key_q    <= '0;
         cache_key_q   <= '0;
         cache_fin_q   <= '0;
         cache_valid_q <= 1'b0;
         mode_q        <= 1'b0;
         rc_q          <= '0;
         out_valid_q   <= 1'b0;
         data_out_q    <= '0;
      end else begin
         state_q       <= state_d;
         blk_q         <= blk_d;
         key_q         <= key_d;
         orig_key_q    <= orig_key_d;
         cache_key_q   <= cache_key_d;
         cache_fin_q   <= cache_fin_d;
         cache_valid_q <= cache_valid_d;
         mode_q        <= mode_d;
         rc_q          <= rc_d;
         out_valid_q   <= out_valid_d;
         data_out_q    <= data_out_d;
      end
   end

   // Next-state: a decrypt miss must wind the key before it can start.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept) state_d = (bus.mode && !hit) ? ST_WIND : ST_ROUND;
         ST_WIND:  if (rc_q == RC_LAST) state_d = ST_ROUND;
         ST_ROUND: if (last_round) state_d = ST_DONE;
         ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath / output updates per state; the cache fills at the end of WIND
   // and after every encrypt, since both have the final key in hand.
   always_comb begin
      blk_d         = blk_q;
      key_d         = key_q;
      orig_key_d    = orig_key_q;
      cache_key_d   = cache_key_q;
      cache_fin_d   = cache_fin_q;
      cache_valid_d = cache_valid_q;
      mode_d        = mode_q;
      rc_d          = rc_q;
      out_valid_d   = out_valid_q;
      data_out_d    = data_out_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               blk_d      = bus.data_in;
               mode_d     = bus.mode;
               orig_key_d = bus.key_in;
               if (bus.mode && hit) begin
                  key_d = cache_fin_q;
                  rc_d  = RC_LAST;
               end else begin
                  key_d = bus.key_in;
                  rc_d  = RC_ONE;
               end
            end
         end
         ST_WIND: begin
            key_d = key_nxt;
            if (rc_q == RC_LAST) begin
               cache_key_d   = orig_key_q;
               cache_fin_d   = key_nxt;
               cache_valid_d = 1'b1;
            end else begin
               rc_d = rc_q + RC_ONE;
            end
         end
         ST_ROUND: begin
            blk_d = new_blk;
            key_d = key_nxt;
            if (last_round) begin
               rc_d        = '0;
               out_valid_d = 1'b1;
               data_out_d  = new_blk ^ key_nxt[KEY_SIZE-1 -: BLK_W];
               if (!mode_q) begin
                  cache_key_d   = orig_key_q;
                  cache_fin_d   = key_nxt;
                  cache_valid_d = 1'b1;
               end
            end else begin
               rc_d = mode_q ? (rc_q - RC_ONE) : (rc_q + RC_ONE);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) out_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_present_core.sv
// Self-checking bench: known-answer vectors, random traffic against a
// behavioural PRESENT model, cache latency, backpressure and mid-run reset.
module tb_present_core;

   localparam int NR = 31;
   localparam int SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
   localparam logic [127:0] M80 = {48'h0, {80{1'b1}}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   present_if #(.KEY_SIZE(80))  b80 ();
   present_if #(.KEY_SIZE(128)) b128 ();

   present_core #(.KEY_SIZE(80), .NUM_ROUNDS(NR)) dut80 (
      .clk(clk), .rst_n(rst_n), .bus(b80)
   );
   present_core #(.KEY_SIZE(128), .NUM_ROUNDS(NR)) dut128 (
      .clk(clk), .rst_n(rst_n), .bus(b128)
   );

   int total = 0;
   int bad = 0;
   logic         cv [2];
   logic [127:0] ck [2];

   // ---------------- reference model ----------------
   function automatic int pbit(input int j);
      return (j == 63) ? 63 : (j * 16) % 63;
   endfunction

   function automatic logic [63:0] sub_layer(input logic [63:0] x, input bit inv);
      logic [63:0] y;
      int v, r;
      y = '0;
      for (int n = 0; n < 16; n++) begin
         v = int'(x[4*n +: 4]);
         r = 0;
         if (!inv) r = SB[v];
         else for (int t = 0; t < 16; t++) if (SB[t] == v) r = t;
         y[4*n +: 4] = 4'(r);
      end
      return y;
   endfunction

   function automatic logic [63:0] perm(input logic [63:0] x, input bit inv);
      logic [63:0] y;
      y = '0;
      for (int j = 0; j < 64; j++) begin
         if (!inv) y[pbit(j)] = x[j];
         else      y[j] = x[pbit(j)];
      end
      return y;
   endfunction

   function automatic logic [127:0] ks_step(input int ks, input logic [127:0] k, input int r);
      logic [127:0] m;
      int top;
      m = (ks == 128) ? {128{1'b1}} : M80;
      k = ((k << 61) | (k >> (ks - 61))) & m;
      top = int'((k >> (ks - 4)) & 128'd15);
      k = (k & ~(128'd15 << (ks - 4))) | (128'(SB[top]) << (ks - 4));
      if (ks == 128) begin
         top = int'((k >> (ks - 8)) & 128'd15);
         k = (k & ~(128'd15 << (ks - 8))) | (128'(SB[top]) << (ks - 8));
      end
      k = k ^ (128'(r) << ((ks == 128) ? 62 : 15));
      return k;
   endfunction

   function automatic logic [63:0] ref_cipher(input int ks, input bit dec,
                                              input logic [127:0] key, input logic [63:0] din);
      logic [63:0]  rk [NR+2];
      logic [127:0] k;
      logic [63:0]  s;
      k = (ks == 128) ? key : (key & M80);
      for (int i = 1; i <= NR + 1; i++) begin
         rk[i] = 64'(k >> (ks - 64));
         if (i <= NR) k = ks_step(ks, k, i);
      end
      if (!dec) begin
         s = din;
         for (int i = 1; i <= NR; i++) s = perm(sub_layer(s ^ rk[i], 0), 0);
         s = s ^ rk[NR+1];
      end else begin
         s = din ^ rk[NR+1];
         for (int i = NR; i >= 1; i--) s = sub_layer(perm(s, 1), 1) ^ rk[i];
      end
      return s;
   endfunction

   // ---------------- check / access helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input bit v, input bit md,
                        input logic [127:0] key, input logic [63:0] d);
      if (sel == 0) begin
         b80.in_valid = v;  b80.mode = md;  b80.key_in = key[79:0];  b80.data_in = d;
      end else begin
         b128.in_valid = v; b128.mode = md; b128.key_in = key;       b128.data_in = d;
      end
   endtask

   task automatic set_ordy(input int sel, input bit r);
      if (sel == 0) b80.out_ready = r;
      else          b128.out_ready = r;
   endtask

   task automatic snap(input int sel, output logic v, output logic r,
                       output logic b, output logic [63:0] q);
      if (sel == 0) begin v = b80.out_valid;  r = b80.in_ready;  b = b80.busy;  q = b80.data_out;  end
      else          begin v = b128.out_valid; r = b128.in_ready; b = b128.busy; q = b128.data_out; end
   endtask

   function automatic logic [127:0] rnd_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Issue one request, scramble the inputs while busy, wait for the result.
   // With hold=1 the result is left pending in DONE.
   task automatic op(input int sel, input bit md, input logic [127:0] key_raw,
                     input logic [63:0] d, input string tag, input bit hold,
                     output logic [63:0] dout);
      logic v, r, b;
      logic [63:0] q;
      logic [127:0] key;
      int w, lat, exp_lat;
      key = (sel == 0) ? (key_raw & M80) : key_raw;
      exp_lat = (md && cv[sel] && ck[sel] == key) ? NR : (md ? 2 * NR : NR);
      w = 0;
      snap(sel, v, r, b, q);
      while (!r && w < 200) begin @(posedge clk); #1; w++; snap(sel, v, r, b, q); end
      chk({tag, "_ready"}, 128'(r), 128'd1);
      drive(sel, 1'b1, md, key, d);
      @(posedge clk); #1;
      drive(sel, 1'b0, ~md, rnd_key(), {$urandom, $urandom});
      lat = 0;
      snap(sel, v, r, b, q);
      while (!v && lat < 200) begin @(posedge clk); #1; lat++; snap(sel, v, r, b, q); end
      chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
      chk({tag, "_data"}, 128'(q), 128'(ref_cipher(sel == 0 ? 80 : 128, md, key, d)));
      cv[sel] = 1'b1;
      ck[sel] = key;
      dout = q;
      if (!hold) begin
         set_ordy(sel, 1'b1);
         @(posedge clk); #1;
         set_ordy(sel, 1'b0);
      end
   endtask

   task automatic pulse_reset();
      logic v, r, b;
      logic [63:0] q;
      rst_n = 1'b0;
      #1;
      snap(0, v, r, b, q);
      chk("rst_out_valid", 128'(v), 128'd0);
      chk("rst_busy", 128'(b), 128'd0);
      chk("rst_in_ready", 128'(r), 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cv[0] = 1'b0;
      cv[1] = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic v, r, b;
      logic [63:0] q, res, exp;
      logic [127:0] pool [3];
      logic [127:0] k;
      bit md;

      cv[0] = 1'b0; cv[1] = 1'b0; ck[0] = '0; ck[1] = '0;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      set_ordy(0, 1'b0);
      set_ordy(1, 1'b0);

      // reset state
      @(posedge clk); #1;
      snap(0, v, r, b, q);
      chk("reset_in_ready", 128'(r), 128'd0);
      chk("reset_out_valid", 128'(v), 128'd0);
      chk("reset_busy", 128'(b), 128'd0);
      chk("reset_data_out", 128'(q), 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      snap(0, v, r, b, q);
      chk("idle_in_ready", 128'(r), 128'd1);
      snap(1, v, r, b, q);
      chk("idle_in_ready128", 128'(r), 128'd1);

      // 80-bit known answers
      op(0, 1'b0, '0, 64'h0, "kat80_enc0", 1'b0, res);
      chk("kat80_enc0_const", 128'(res), 128'h5579C1387B228445);
      op(0, 1'b0, M80, {64{1'b1}}, "kat80_enc1", 1'b0, res);
      chk("kat80_enc1_const", 128'(res), 128'h3333DCD3213210D2);
      op(0, 1'b1, M80, 64'h3333DCD3213210D2, "kat80_dec_hit", 1'b0, res);
      chk("kat80_dec_hit_const", 128'(res), 128'hFFFFFFFFFFFFFFFF);

      // cold-cache decrypt then the same request again
      pulse_reset();
      op(0, 1'b1, M80, 64'hE72C46C0F5945049, "kat80_dec_miss", 1'b0, res);
      chk("kat80_dec_miss_const", 128'(res), 128'h0);
      op(0, 1'b1, M80, 64'hE72C46C0F5945049, "kat80_dec_rep", 1'b0, res);
      chk("kat80_dec_rep_const", 128'(res), 128'h0);

      // 128-bit known answer and round trip
      op(1, 1'b0, '0, 64'h0, "kat128_enc", 1'b0, res);
      chk("kat128_enc_const", 128'(res), 128'h96DB702A2E6900AF);
      op(1, 1'b1, '0, res, "kat128_dec", 1'b0, res);
      chk("kat128_dec_const", 128'(res), 128'h0);

      // random traffic over a small key pool so hits and misses both occur
      for (int i = 0; i < 3; i++) pool[i] = rnd_key();
      for (int i = 0; i < 16; i++) begin
         md = 1'($urandom_range(0, 1));
         op(0, md, pool[$urandom_range(0, 2)], {$urandom, $urandom}, "rnd80", 1'b0, res);
      end
      for (int i = 0; i < 6; i++) begin
         md = 1'($urandom_range(0, 1));
         op(1, md, pool[$urandom_range(0, 2)], {$urandom, $urandom}, "rnd128", 1'b0, res);
      end

      // backpressure: result must hold, new requests ignored
      k = rnd_key() & M80;
      q = {$urandom, $urandom};
      exp = ref_cipher(80, 1'b0, k, q);
      op(0, 1'b0, k, q, "bp", 1'b1, res);
      for (int i = 0; i < 10; i++) begin
         drive(0, 1'b1, 1'($urandom_range(0, 1)), rnd_key(), {$urandom, $urandom});
         @(posedge clk); #1;
         snap(0, v, r, b, q);
         chk("bp_hold_data", 128'(q), 128'(exp));
         chk("bp_hold_valid", 128'(v), 128'd1);
         chk("bp_in_ready", 128'(r), 128'd0);
      end
      drive(0, 1'b0, 1'b0, '0, '0);
      set_ordy(0, 1'b1);
      @(posedge clk); #1;
      set_ordy(0, 1'b0);
      snap(0, v, r, b, q);
      chk("bp_release_valid", 128'(v), 128'd0);
      chk("bp_release_busy", 128'(b), 128'd0);
      chk("bp_release_ready", 128'(r), 128'd1);
      @(posedge clk); #1;
      snap(0, v, r, b, q);
      chk("bp_no_ghost_busy", 128'(b), 128'd0);

      // reset mid-ROUND aborts and cold-starts the cache
      k = rnd_key() & M80;
      op(0, 1'b0, k, {$urandom, $urandom}, "pre_abort", 1'b0, res);
      drive(0, 1'b1, 1'b0, k, {$urandom, $urandom});
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, '0, '0);
      repeat (15) @(posedge clk);
      #1;
      pulse_reset();
      snap(0, v, r, b, q);
      chk("abort_no_valid", 128'(v), 128'd0);
      op(0, 1'b1, k, {$urandom, $urandom}, "post_abort_dec", 1'b0, res);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: no summary reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/present_core.md
Name: present_core

Overview:
- Iterative PRESENT block-cipher engine: one round per clock, both encrypt and decrypt, 80- or 128-bit keys, configurable round count.
- Next generation of the decrypt-only datapath. Adds a valid/ready handshake, an on-the-fly key schedule instead of a stored round-key array, and a one-entry cache of the wound-up decryption key.
- Sits between the host-side request FIFO and the result FIFO of the crypto subsystem.

Parameters:
- KEY_SIZE, 80, key width; legal values 80 or 128, anything else is an elaboration error.
- NUM_ROUNDS, 31, rounds per block; legal 1..31.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  engine can accept a request
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- key_in  in  KEY_SIZE  original (round-1) key; sampled on accept
- data_in  in  64  plaintext or ciphertext; sampled on accept
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- data_out  out  64  result block; held stable while out_valid=1 and out_ready=0
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: in_ready=0 while Reset=0, then 1 in IDLE; out_valid=0; busy=0; data_out=0; cache_valid=0; FSM=IDLE; round counter=0.
- Reset asserted mid-operation aborts the block: no output, cache invalidated.
- FSM states: IDLE, WIND, ROUND, DONE.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready. On accept, latch state=data_in, key register, mode.
- Transitions from IDLE on accept:
  - Encrypt: to ROUND; key reg = key_in; rc=1.
  - Decrypt, cache hit (cache_valid and key_in == cached_key): to ROUND; key reg = cached_final_key; rc=NUM_ROUNDS.
  - Decrypt, miss: to WIND; key reg = key_in; rc=1.
- WIND: per cycle, key = fwd_update(key, rc), rc++. After NUM_ROUNDS cycles:
  - cached_key = original key; cached_final_key = key; cache_valid=1.
  - Go to ROUND with rc=NUM_ROUNDS.
- Encrypt round, per cycle: state = P(S(state ^ key[KEY_SIZE-1 -: 64])); key = fwd_update(key, rc); rc++.
- Decrypt round, per cycle: state = Sinv(Pinv(state ^ key[KEY_SIZE-1 -: 64])); key = inv_update(key, rc); rc--.
- The edge completing the last round writes data_out = new_state ^ new_key[KEY_SIZE-1 -: 64], sets out_valid=1, and enters DONE.
- A completed encrypt also loads the cache with (original key, final key).
- fwd_update, 80-bit: rotate left 61; S-box on bits [79:76]; bits [19:15] ^= rc.
- fwd_update, 128-bit: rotate left 61; S-box on [127:124] and [123:120]; bits [66:62] ^= rc.
- inv_update is the exact inverse: undo rc XOR, inverse S-box, rotate right 61. rc is 5 bits; no wrap occurs for legal NUM_ROUNDS.
- DONE: when out_ready=1, clear out_valid and return to IDLE. Earliest next accept is the following cycle.
- Latency, accept edge to out_valid high:
  - encrypt: NUM_ROUNDS cycles
  - decrypt, cache hit: NUM_ROUNDS cycles
  - decrypt, miss: 2*NUM_ROUNDS cycles
- mode, key_in and data_in changing while busy have no effect.

Decomposition:
- Package present_pkg holds:
  - KEY_SIZE legality check and block-width constant 64
  - FSM state enum
  - sbox/inv_sbox functions (4-bit) and player/inv_player functions (64-bit)
- Sub-module present_key_step: combinational single-step key update with inputs key, rc, dir and parameter KEY_SIZE. Shared by WIND and ROUND.

Test Plan:
- 80-bit encrypt, key 0, pt 0 -> data_out 5579C1387B228445, out_valid at accept+31.
- 80-bit encrypt, key all-ones, pt all-ones -> 3333DCD3213210D2. Then decrypt 3333DCD3213210D2 with the same key -> FFFFFFFFFFFFFFFF at accept+31 (cache hit).
- 80-bit decrypt, key all-ones, ct E72C46C0F5945049 after reset (cache cold) -> 0000000000000000 at accept+62. Repeating the same request -> accept+31.
- KEY_SIZE=128 instance, key 0, pt 0 -> 96DB702A2E6900AF; decrypt round-trips back to 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> data_out stable, in_ready=0, in_valid ignored. Release -> IDLE the next cycle.
- Reset pulse mid-ROUND (cycle 15) -> out_valid=0, busy=0. The next decrypt with the same key takes the miss latency.
